// File: rtl/bsg_add_serial_chunked_pkg.sv
// bsg_add_serial_chunked_pkg: shared state encoding for the chunked serial adder.
package bsg_add_serial_chunked_pkg;
  typedef enum logic [1:0] {
    eIdle = 2'b00,
    eBusy = 2'b01,
    eDone = 2'b10
  } state_e;
endpackage

// File: rtl/bsg_add_serial_chunk_slice.sv
// bsg_add_serial_chunk_slice: combinational width_p-bit adder slice built from p/g terms and a
// Kogge-Stone prefix; the carry-in is folded into bit 0 so every prefix group reaches down to it.
module bsg_add_serial_chunk_slice #(
  parameter int width_p = 16
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               c_i,
  output logic [width_p-1:0] s_o,
  output logic               c_o,
  output logic               c_msb_o
);
  function automatic logic [width_p:0] prefix_carries(
    input logic [width_p-1:0] g,
    input logic [width_p-1:0] p,
    input logic               c
  );
    logic [width_p-1:0] gg, pp, gn, pn;
    gg    = g;
    gg[0] = g[0] | (p[0] & c);
    pp    = p;
    for (int d = 1; d < width_p; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < width_p; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        // grey cells (lower group already reaches bit 0) need no propagate
        if (i >= 2 * d) pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    return {gg, c};
  endfunction

  logic [width_p-1:0] w_p, w_g;
  logic [width_p:0]   w_c;

  assign w_p     = a_i ^ b_i;
  assign w_g     = a_i & b_i;
  assign w_c     = prefix_carries(w_g, w_p, c_i);
  assign s_o     = w_p ^ w_c[width_p-1:0];
  assign c_o     = w_c[width_p];
  assign c_msb_o = w_c[width_p-1];
endmodule

// File: rtl/bsg_add_serial_chunked.sv
// bsg_add_serial_chunked: multi-cycle add/sub resolving chunk_p bits per cycle with a registered carry.
// Define BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN to add the signed-overflow output ov_o.
module bsg_add_serial_chunked
  import bsg_add_serial_chunked_pkg::*;
#(
  parameter int width_p = 64,
  parameter int chunk_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               sub_i,
  output logic               v_o,
  output logic [width_p-1:0] sum_o,
  output logic               c_o,
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
  output logic               ov_o,
`endif
  input  logic               yumi_i
);
  localparam int chunks_lp = width_p / chunk_p;
  localparam int cnt_w_lp  = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;

  if (chunk_p < 1 || (width_p % chunk_p) != 0) begin : g_bad_params
    $error("bsg_add_serial_chunked: width_p must be a positive multiple of chunk_p");
  end

  state_e              r_state, w_state_nxt;
  logic [width_p-1:0]  r_a, r_b, r_sum;
  logic                r_c;
  logic [cnt_w_lp-1:0] r_cnt;
  logic [chunk_p-1:0]  w_s;
  logic                w_cout, w_last, w_acc;

  assign ready_o = (r_state == eIdle);
  assign v_o     = (r_state == eDone);
  assign sum_o   = r_sum;
  assign c_o     = r_c;
  assign w_acc   = v_i & ready_o;
  assign w_last  = (r_cnt == cnt_w_lp'(chunks_lp - 1));

`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
  logic r_ov, w_cmsb;
  assign ov_o = r_ov;
`endif

  bsg_add_serial_chunk_slice #(.width_p(chunk_p)) u_slice (
    .a_i     (r_a[chunk_p-1:0]),
    .b_i     (r_b[chunk_p-1:0]),
    .c_i     (r_c),
    .s_o     (w_s),
    .c_o     (w_cout),
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
    .c_msb_o (w_cmsb)
`else
    .c_msb_o ()
`endif
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= eIdle;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == eIdle && w_acc)  ? eBusy :
                  (r_state == eBusy && w_last) ? eDone :
                  (r_state == eDone && yumi_i) ? eIdle : r_state;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_a   <= a_i;
      r_b   <= sub_i ? ~b_i : b_i;
      r_c   <= sub_i;
      r_cnt <= '0;
    end else if (r_state == eBusy) begin
      r_a   <= r_a >> chunk_p;
      r_b   <= r_b >> chunk_p;
      // slice results enter at the MSB so after chunks_lp steps the word is in place
      r_sum <= width_p'({w_s, r_sum} >> chunk_p);
      r_c   <= w_cout;
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
  // updated every busy cycle; the value left after the last slice is the MSB overflow
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)               r_ov <= 1'b0;
    else if (r_state == eBusy)    r_ov <= w_cmsb ^ w_cout;
  end
`endif
endmodule

// File: tb/tb_bsg_add_serial_chunked.sv
// tb_bsg_add_serial_chunked: randomized and directed checks against an arithmetic reference model.
module tb_bsg_add_serial_chunked;
  localparam int W = 64;
  localparam int C = 16;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         v_i = 1'b0, sub_i = 1'b0, yumi_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         ready_o, v_o, c_o;
  logic [W-1:0] sum_o;
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
  logic         ov_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  bsg_add_serial_chunked #(.width_p(W), .chunk_p(C)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .sub_i     (sub_i),
    .v_o       (v_o),
    .sum_o     (sum_o),
    .c_o       (c_o),
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
    .ov_o      (ov_o),
`endif
    .yumi_i    (yumi_i)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
  endfunction

  function automatic logic ref_ov(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [W:0] r;
    r = s ? ($signed({a[W-1], a}) - $signed({b[W-1], b})) : ($signed({a[W-1], a}) + $signed({b[W-1], b}));
    return r[W] != r[W-1];
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int yd,
                        output logic [W-1:0] so, output logic co, output logic ovo, output int lat);
    int w;
    @(negedge clk);
    a_i = a; b_i = b; sub_i = s; v_i = 1'b1;
    w = 0;
    while (!ready_o && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 v_i = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!v_o && lat < 50);
    so = sum_o; co = c_o;
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
    ovo = ov_o;
`else
    ovo = 1'b0;
`endif
    repeat (yd) @(negedge clk);
    @(negedge clk); yumi_i = 1'b1;
    @(posedge clk);
    #1 yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    n_chk++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v got %b want 0", v_o); end
    n_chk++; if (sum_o !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 0", sum_o); end
    n_chk++; if (c_o !== 1'b0) begin n_fail++; $display("FAIL reset_c got %b want 0", c_o); end
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
    n_chk++; if (ov_o !== 1'b0) begin n_fail++; $display("FAIL reset_ov got %b want 0", ov_o); end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF, 64'd5, 64'd7};
    logic [W-1:0] tb [4] = '{64'd1, 64'd1, 64'd7, 64'd5};
    logic         ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] so; logic co, ovo; int lat;
    logic [W:0]   e;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], ts[i], 0, so, co, ovo, lat);
      e = ref_sum(ta[i], tb[i], ts[i]);
      n_chk++; if (lat != N) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, N); end
      n_chk++; if (so !== e[W-1:0]) begin n_fail++; $display("FAIL dir%0d_sum got %h want %h", i, so, e[W-1:0]); end
      n_chk++; if (co !== e[W]) begin n_fail++; $display("FAIL dir%0d_c got %b want %b", i, co, e[W]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, so; logic s, co, ovo; int lat;
    logic [W:0]   e;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 5 == 1) b = ~a;
      if (i % 7 == 2) b = a;
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, int'($urandom_range(0, 3)), so, co, ovo, lat);
      e = ref_sum(a, b, s);
      n_chk++; if (so !== e[W-1:0] || co !== e[W] || lat != N)
        begin n_fail++; $display("FAIL rnd%0d got sum=%h c=%b lat=%0d want sum=%h c=%b lat=%0d", i, so, co, lat, e[W-1:0], e[W], N); end
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
      n_chk++; if (ovo !== ref_ov(a, b, s)) begin n_fail++; $display("FAIL rnd%0d_ov got %b want %b", i, ovo, ref_ov(a, b, s)); end
`endif
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] a1 = 64'h1234_5678_9ABC_DEF0, b1 = 64'h0FED_CBA9_8765_4321;
    logic [W-1:0] a2 = 64'h8000_0000_0000_0001, b2 = 64'h0000_0000_0001_0003;
    logic [W-1:0] s0; logic [W:0] e; int lat;
    @(negedge clk); a_i = a1; b_i = b1; sub_i = 1'b0; v_i = 1'b1;
    @(posedge clk);
    #1 a_i = a2; b_i = b2; sub_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!v_o && lat < 50);
    e = ref_sum(a1, b1, 1'b0);
    s0 = sum_o;
    n_chk++; if (s0 !== e[W-1:0]) begin n_fail++; $display("FAIL hold_first_sum got %h want %h", s0, e[W-1:0]); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_chk++; if (v_o !== 1'b1 || ready_o !== 1'b0 || sum_o !== s0)
        begin n_fail++; $display("FAIL hold%0d got v=%b ready=%b sum=%h want v=1 ready=0 sum=%h", i, v_o, ready_o, sum_o, s0); end
    end
    @(negedge clk); yumi_i = 1'b1;
    @(posedge clk);
    #1 yumi_i = 1'b0;
    n_chk++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin n_fail++; $display("FAIL hold_release got ready=%b v=%b want ready=1 v=0", ready_o, v_o); end
    @(posedge clk);
    #1 v_i = 1'b0;
    n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_next_accept got ready=%b want 0", ready_o); end
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!v_o && lat < 50);
    e = ref_sum(a2, b2, 1'b1);
    n_chk++; if (sum_o !== e[W-1:0] || c_o !== e[W] || lat != N)
      begin n_fail++; $display("FAIL hold_second got sum=%h c=%b lat=%0d want sum=%h c=%b lat=%0d", sum_o, c_o, lat, e[W-1:0], e[W], N); end
    @(negedge clk); yumi_i = 1'b1;
    @(posedge clk);
    #1 yumi_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] so; logic co, ovo; int lat;
    @(negedge clk); a_i = 64'hFFFF_0000_FFFF_0000; b_i = 64'h0001_0001_0001_0001; sub_i = 1'b0; v_i = 1'b1;
    @(posedge clk);
    #1 v_i = 1'b0;
    @(posedge clk);
    #3 reset_n_i = 1'b0;
    #1;
    n_chk++; if (v_o !== 1'b0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset got v=%b ready=%b want v=0 ready=1", v_o, ready_o); end
    n_chk++; if (sum_o !== '0 || c_o !== 1'b0) begin n_fail++; $display("FAIL midreset_regs got sum=%h c=%b want 0 0", sum_o, c_o); end
    @(negedge clk); reset_n_i = 1'b1;
    run_op(64'd3, 64'd4, 1'b0, 0, so, co, ovo, lat);
    n_chk++; if (so !== 64'd7 || co !== 1'b0 || lat != N)
      begin n_fail++; $display("FAIL post_reset_op got sum=%h c=%b lat=%0d want sum=7 c=0 lat=%0d", so, co, lat, N); end
  endtask

`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
  task automatic test_overflow();
    logic [W-1:0] so; logic co, ovo; int lat;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, so, co, ovo, lat);
    n_chk++; if (so !== 64'h8000_0000_0000_0000 || ovo !== 1'b1 || co !== 1'b0)
      begin n_fail++; $display("FAIL ov_pos got sum=%h ov=%b c=%b want sum=8000000000000000 ov=1 c=0", so, ovo, co); end
    run_op(64'd1, 64'd1, 1'b0, 0, so, co, ovo, lat);
    n_chk++; if (so !== 64'd2 || ovo !== 1'b0)
      begin n_fail++; $display("FAIL ov_none got sum=%h ov=%b want sum=2 ov=0", so, ovo); end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset_n_i = 1'b1;
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef BSG_ADD_SERIAL_CHUNKED_OVERFLOW_EN
    test_overflow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
